aes_key_expander: RTL and testbench



---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_sbox.sv | 45 ++++
 rtl/aes_key_expander.sv | 115 +++++++++++
 tb/tb_aes_key_expander.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-schedule constants and FSM state type
package aes_pkg;

  localparam int AES_KEY_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } kx_state_e;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box, one byte
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  always_comb begin
    data_o = 8'h00;
    case (data_i)
      8'h00: data_o = 8'h63; 8'h01: data_o = 8'h7c; 8'h02: data_o = 8'h77; 8'h03: data_o = 8'h7b; 8'h04: data_o = 8'hf2; 8'h05: data_o = 8'h6b; 8'h06: data_o = 8'h6f; 8'h07: data_o = 8'hc5;
      8'h08: data_o = 8'h30; 8'h09: data_o = 8'h01; 8'h0a: data_o = 8'h67; 8'h0b: data_o = 8'h2b; 8'h0c: data_o = 8'hfe; 8'h0d: data_o = 8'hd7; 8'h0e: data_o = 8'hab; 8'h0f: data_o = 8'h76;
      8'h10: data_o = 8'hca; 8'h11: data_o = 8'h82; 8'h12: data_o = 8'hc9; 8'h13: data_o = 8'h7d; 8'h14: data_o = 8'hfa; 8'h15: data_o = 8'h59; 8'h16: data_o = 8'h47; 8'h17: data_o = 8'hf0;
      8'h18: data_o = 8'had; 8'h19: data_o = 8'hd4; 8'h1a: data_o = 8'ha2; 8'h1b: data_o = 8'haf; 8'h1c: data_o = 8'h9c; 8'h1d: data_o = 8'ha4; 8'h1e: data_o = 8'h72; 8'h1f: data_o = 8'hc0;
      8'h20: data_o = 8'hb7; 8'h21: data_o = 8'hfd; 8'h22: data_o = 8'h93; 8'h23: data_o = 8'h26; 8'h24: data_o = 8'h36; 8'h25: data_o = 8'h3f; 8'h26: data_o = 8'hf7; 8'h27: data_o = 8'hcc;
      8'h28: data_o = 8'h34; 8'h29: data_o = 8'ha5; 8'h2a: data_o = 8'he5; 8'h2b: data_o = 8'hf1; 8'h2c: data_o = 8'h71; 8'h2d: data_o = 8'hd8; 8'h2e: data_o = 8'h31; 8'h2f: data_o = 8'h15;
      8'h30: data_o = 8'h04; 8'h31: data_o = 8'hc7; 8'h32: data_o = 8'h23; 8'h33: data_o = 8'hc3; 8'h34: data_o = 8'h18; 8'h35: data_o = 8'h96; 8'h36: data_o = 8'h05; 8'h37: data_o = 8'h9a;
      8'h38: data_o = 8'h07; 8'h39: data_o = 8'h12; 8'h3a: data_o = 8'h80; 8'h3b: data_o = 8'he2; 8'h3c: data_o = 8'heb; 8'h3d: data_o = 8'h27; 8'h3e: data_o = 8'hb2; 8'h3f: data_o = 8'h75;
      8'h40: data_o = 8'h09; 8'h41: data_o = 8'h83; 8'h42: data_o = 8'h2c; 8'h43: data_o = 8'h1a; 8'h44: data_o = 8'h1b; 8'h45: data_o = 8'h6e; 8'h46: data_o = 8'h5a; 8'h47: data_o = 8'ha0;
      8'h48: data_o = 8'h52; 8'h49: data_o = 8'h3b; 8'h4a: data_o = 8'hd6; 8'h4b: data_o = 8'hb3; 8'h4c: data_o = 8'h29; 8'h4d: data_o = 8'he3; 8'h4e: data_o = 8'h2f; 8'h4f: data_o = 8'h84;
      8'h50: data_o = 8'h53; 8'h51: data_o = 8'hd1; 8'h52: data_o = 8'h00; 8'h53: data_o = 8'hed; 8'h54: data_o = 8'h20; 8'h55: data_o = 8'hfc; 8'h56: data_o = 8'hb1; 8'h57: data_o = 8'h5b;
      8'h58: data_o = 8'h6a; 8'h59: data_o = 8'hcb; 8'h5a: data_o = 8'hbe; 8'h5b: data_o = 8'h39; 8'h5c: data_o = 8'h4a; 8'h5d: data_o = 8'h4c; 8'h5e: data_o = 8'h58; 8'h5f: data_o = 8'hcf;
      8'h60: data_o = 8'hd0; 8'h61: data_o = 8'hef; 8'h62: data_o = 8'haa; 8'h63: data_o = 8'hfb; 8'h64: data_o = 8'h43; 8'h65: data_o = 8'h4d; 8'h66: data_o = 8'h33; 8'h67: data_o = 8'h85;
      8'h68: data_o = 8'h45; 8'h69: data_o = 8'hf9; 8'h6a: data_o = 8'h02; 8'h6b: data_o = 8'h7f; 8'h6c: data_o = 8'h50; 8'h6d: data_o = 8'h3c; 8'h6e: data_o = 8'h9f; 8'h6f: data_o = 8'ha8;
      8'h70: data_o = 8'h51; 8'h71: data_o = 8'ha3; 8'h72: data_o = 8'h40; 8'h73: data_o = 8'h8f; 8'h74: data_o = 8'h92; 8'h75: data_o = 8'h9d; 8'h76: data_o = 8'h38; 8'h77: data_o = 8'hf5;
      8'h78: data_o = 8'hbc; 8'h79: data_o = 8'hb6; 8'h7a: data_o = 8'hda; 8'h7b: data_o = 8'h21; 8'h7c: data_o = 8'h10; 8'h7d: data_o = 8'hff; 8'h7e: data_o = 8'hf3; 8'h7f: data_o = 8'hd2;
      8'h80: data_o = 8'hcd; 8'h81: data_o = 8'h0c; 8'h82: data_o = 8'h13; 8'h83: data_o = 8'hec; 8'h84: data_o = 8'h5f; 8'h85: data_o = 8'h97; 8'h86: data_o = 8'h44; 8'h87: data_o = 8'h17;
      8'h88: data_o = 8'hc4; 8'h89: data_o = 8'ha7; 8'h8a: data_o = 8'h7e; 8'h8b: data_o = 8'h3d; 8'h8c: data_o = 8'h64; 8'h8d: data_o = 8'h5d; 8'h8e: data_o = 8'h19; 8'h8f: data_o = 8'h73;
      8'h90: data_o = 8'h60; 8'h91: data_o = 8'h81; 8'h92: data_o = 8'h4f; 8'h93: data_o = 8'hdc; 8'h94: data_o = 8'h22; 8'h95: data_o = 8'h2a; 8'h96: data_o = 8'h90; 8'h97: data_o = 8'h88;
      8'h98: data_o = 8'h46; 8'h99: data_o = 8'hee; 8'h9a: data_o = 8'hb8; 8'h9b: data_o = 8'h14; 8'h9c: data_o = 8'hde; 8'h9d: data_o = 8'h5e; 8'h9e: data_o = 8'h0b; 8'h9f: data_o = 8'hdb;
      8'ha0: data_o = 8'he0; 8'ha1: data_o = 8'h32; 8'ha2: data_o = 8'h3a; 8'ha3: data_o = 8'h0a; 8'ha4: data_o = 8'h49; 8'ha5: data_o = 8'h06; 8'ha6: data_o = 8'h24; 8'ha7: data_o = 8'h5c;
      8'ha8: data_o = 8'hc2; 8'ha9: data_o = 8'hd3; 8'haa: data_o = 8'hac; 8'hab: data_o = 8'h62; 8'hac: data_o = 8'h91; 8'had: data_o = 8'h95; 8'hae: data_o = 8'he4; 8'haf: data_o = 8'h79;
      8'hb0: data_o = 8'he7; 8'hb1: data_o = 8'hc8; 8'hb2: data_o = 8'h37; 8'hb3: data_o = 8'h6d; 8'hb4: data_o = 8'h8d; 8'hb5: data_o = 8'hd5; 8'hb6: data_o = 8'h4e; 8'hb7: data_o = 8'ha9;
      8'hb8: data_o = 8'h6c; 8'hb9: data_o = 8'h56; 8'hba: data_o = 8'hf4; 8'hbb: data_o = 8'hea; 8'hbc: data_o = 8'h65; 8'hbd: data_o = 8'h7a; 8'hbe: data_o = 8'hae; 8'hbf: data_o = 8'h08;
      8'hc0: data_o = 8'hba; 8'hc1: data_o = 8'h78; 8'hc2: data_o = 8'h25; 8'hc3: data_o = 8'h2e; 8'hc4: data_o = 8'h1c; 8'hc5: data_o = 8'ha6; 8'hc6: data_o = 8'hb4; 8'hc7: data_o = 8'hc6;
      8'hc8: data_o = 8'he8; 8'hc9: data_o = 8'hdd; 8'hca: data_o = 8'h74; 8'hcb: data_o = 8'h1f; 8'hcc: data_o = 8'h4b; 8'hcd: data_o = 8'hbd; 8'hce: data_o = 8'h8b; 8'hcf: data_o = 8'h8a;
      8'hd0: data_o = 8'h70; 8'hd1: data_o = 8'h3e; 8'hd2: data_o = 8'hb5; 8'hd3: data_o = 8'h66; 8'hd4: data_o = 8'h48; 8'hd5: data_o = 8'h03; 8'hd6: data_o = 8'hf6; 8'hd7: data_o = 8'h0e;
      8'hd8: data_o = 8'h61; 8'hd9: data_o = 8'h35; 8'hda: data_o = 8'h57; 8'hdb: data_o = 8'hb9; 8'hdc: data_o = 8'h86; 8'hdd: data_o = 8'hc1; 8'hde: data_o = 8'h1d; 8'hdf: data_o = 8'h9e;
      8'he0: data_o = 8'he1; 8'he1: data_o = 8'hf8; 8'he2: data_o = 8'h98; 8'he3: data_o = 8'h11; 8'he4: data_o = 8'h69; 8'he5: data_o = 8'hd9; 8'he6: data_o = 8'h8e; 8'he7: data_o = 8'h94;
      8'he8: data_o = 8'h9b; 8'he9: data_o = 8'h1e; 8'hea: data_o = 8'h87; 8'heb: data_o = 8'he9; 8'hec: data_o = 8'hce; 8'hed: data_o = 8'h55; 8'hee: data_o = 8'h28; 8'hef: data_o = 8'hdf;
      8'hf0: data_o = 8'h8c; 8'hf1: data_o = 8'ha1; 8'hf2: data_o = 8'h89; 8'hf3: data_o = 8'h0d; 8'hf4: data_o = 8'hbf; 8'hf5: data_o = 8'he6; 8'hf6: data_o = 8'h42; 8'hf7: data_o = 8'h68;
      8'hf8: data_o = 8'h41; 8'hf9: data_o = 8'h99; 8'hfa: data_o = 8'h2d; 8'hfb: data_o = 8'h0f; 8'hfc: data_o = 8'hb0; 8'hfd: data_o = 8'h54; 8'hfe: data_o = 8'hbb; 8'hff: data_o = 8'h16;
    endcase
  end

endmodule

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - iterative AES-128 key schedule, one round key per clock
import aes_pkg::*;

module aes_key_expander #(
  parameter int WIDTH = AES_KEY_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] key_i,
  output logic [WIDTH-1:0] key_1_o,
  output logic [WIDTH-1:0] key_2_o,
  output logic [WIDTH-1:0] key_3_o,
  output logic [WIDTH-1:0] key_4_o,
  output logic [WIDTH-1:0] key_5_o,
  output logic [WIDTH-1:0] key_6_o,
  output logic [WIDTH-1:0] key_7_o,
  output logic [WIDTH-1:0] key_8_o,
  output logic [WIDTH-1:0] key_9_o,
  output logic [WIDTH-1:0] key_10_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             keys_valid_o
);

  kx_state_e        state_q, state_d;
  logic [3:0]       rnd_q;
  logic [WIDTH-1:0] prev_key_q;
  logic [WIDTH-1:0] rk_q [1:10];
  logic             keys_valid_q;
  logic [10:1]      rk_we;
  logic             accept;

  logic [31:0] w0, w1, w2, w3, rot_w, sub_w, t_w, n0, n1, n2, n3;
  logic [7:0]  rcon_b;
  logic [WIDTH-1:0] next_key;

  assign w0 = prev_key_q[127:96];
  assign w1 = prev_key_q[95:64];
  assign w2 = prev_key_q[63:32];
  assign w3 = prev_key_q[31:0];
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (.data_i(rot_w[8*g +: 8]), .data_o(sub_w[8*g +: 8]));
  end

  // rnd only leaves 1..10 outside EXPAND, where the result is never written
  assign rcon_b = (rnd_q >= 4'd1 && rnd_q <= 4'd10) ? RCON[rnd_q] : 8'h00;
  assign t_w    = sub_w ^ {rcon_b, 24'h0};
  assign n0     = w0 ^ t_w;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  assign accept = start_i && (state_q == ST_IDLE || state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_i) state_d = ST_EXPAND;
      ST_EXPAND: if (rnd_q == 4'd10) state_d = ST_DONE;
      ST_DONE:   state_d = start_i ? ST_EXPAND : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rk_we = '0;
    for (int i = 1; i <= 10; i++) begin
      rk_we[i] = (state_q == ST_EXPAND) && (rnd_q == 4'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      rnd_q        <= 4'd0;
      prev_key_q   <= '0;
      keys_valid_q <= 1'b0;
      for (int i = 1; i <= 10; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        prev_key_q   <= key_i;
        rnd_q        <= 4'd1;
        keys_valid_q <= 1'b0;
      end else if (state_q == ST_EXPAND) begin
        prev_key_q <= next_key;
        rnd_q      <= rnd_q + 4'd1;
        if (rnd_q == 4'd10) keys_valid_q <= 1'b1;
      end
      for (int i = 1; i <= 10; i++) begin
        if (rk_we[i]) rk_q[i] <= next_key;
      end
    end
  end

  assign busy_o       = (state_q == ST_EXPAND);
  assign done_o       = (state_q == ST_DONE);
  assign keys_valid_o = keys_valid_q;

  assign key_1_o  = rk_q[1];
  assign key_2_o  = rk_q[2];
  assign key_3_o  = rk_q[3];
  assign key_4_o  = rk_q[4];
  assign key_5_o  = rk_q[5];
  assign key_6_o  = rk_q[6];
  assign key_7_o  = rk_q[7];
  assign key_8_o  = rk_q[8];
  assign key_9_o  = rk_q[9];
  assign key_10_o = rk_q[10];

endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - randomized self-checking bench with a FIPS-197 key-schedule model
module tb_aes_key_expander;

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic         start_i = 1'b0;
  logic [127:0] key_i = '0;
  logic [127:0] dut_k [1:10];
  logic         busy_o, done_o, keys_valid_o;

  aes_key_expander #(.WIDTH(128)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .key_i(key_i),
    .key_1_o(dut_k[1]), .key_2_o(dut_k[2]), .key_3_o(dut_k[3]), .key_4_o(dut_k[4]),
    .key_5_o(dut_k[5]), .key_6_o(dut_k[6]), .key_7_o(dut_k[7]), .key_8_o(dut_k[8]),
    .key_9_o(dut_k[9]), .key_10_o(dut_k[10]),
    .busy_o(busy_o), .done_o(done_o), .keys_valid_o(keys_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // S-box derived from GF(2^8) inversion plus the affine map
  logic [7:0] sbox_tbl [0:255];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    logic [15:0] d = {v, v};
    return d[15-s -: 8];
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_tbl[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  logic [127:0] m_sched [1:10];

  task automatic compute_sched(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tbl[tmp[31:24]], sbox_tbl[tmp[23:16]], sbox_tbl[tmp[15:8]], sbox_tbl[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 1; r <= 10; r++) m_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Event-level model: on an accepted start, key n appears n edges later
  logic [127:0] m_keys [1:10];
  int m_cnt = -1;
  bit m_done = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 1; i <= 10; i++) m_keys[i] = '0;
      m_cnt = -1; m_done = 1'b0; m_valid = 1'b0;
    end else if (m_cnt >= 0) begin
      m_cnt++;
      m_keys[m_cnt] = m_sched[m_cnt];
      if (m_cnt == 10) begin m_valid = 1'b1; m_done = 1'b1; m_cnt = -1; end
    end else begin
      m_done = 1'b0;
      if (start_i) begin compute_sched(key_i); m_cnt = 0; m_valid = 1'b0; end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("busy", {127'b0, busy_o}, {127'b0, m_cnt >= 0});
      chk("done", {127'b0, done_o}, {127'b0, m_done});
      chk("keys_valid", {127'b0, keys_valid_o}, {127'b0, m_valid});
      for (int i = 1; i <= 10; i++) chk($sformatf("key_%0d", i), dut_k[i], m_keys[i]);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run(input logic [127:0] k, input bit noise,
                     output int lat, output int bcnt, output int vcnt);
    start_i = 1'b1; key_i = k;
    step();
    start_i = 1'b0;
    lat = 0; bcnt = 0; vcnt = 0;
    while (!done_o && lat < 30) begin
      if (busy_o) bcnt++;
      if (!keys_valid_o) vcnt++;
      if (noise && busy_o) begin
        start_i = 1'($urandom_range(0, 1));
        key_i = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
      lat++;
    end
    start_i = 1'b0; key_i = k;
  endtask

  int lat, bcnt, vcnt;
  logic [127:0] rk;

  initial begin
    build_sbox();
    chk("model_sbox_00", {120'b0, sbox_tbl[8'h00]}, 128'h63);
    chk("model_sbox_53", {120'b0, sbox_tbl[8'h53]}, 128'hed);
    compute_sched(128'h0);
    chk("model_zero_k1", m_sched[1], 128'h62636363626363636263636362636363);
    chk("model_zero_k10", m_sched[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    step(); step();
    rst_n_i = 1'b1;
    chk_en = 1'b1;
    chk("reset_busy", {127'b0, busy_o}, 128'h0);
    chk("reset_key10", dut_k[10], 128'h0);
    step();

    run(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, lat, bcnt, vcnt);
    chk("a1_latency", 128'(lat), 128'd10);
    chk("a1_key1", dut_k[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("a1_key10", dut_k[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    step(); step();

    run(128'h0, 1'b1, lat, bcnt, vcnt);
    chk("zero_busy_cycles", 128'(bcnt), 128'd10);
    chk("zero_key1", dut_k[1], 128'h62636363626363636263636362636363);
    chk("zero_key10", dut_k[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    run(128'h000102030405060708090a0b0c0d0e0f, 1'b0, lat, bcnt, vcnt);
    chk("b2b_invalid_cycles", 128'(vcnt), 128'd10);
    chk("b2b_key10", dut_k[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    step();

    start_i = 1'b1; key_i = {$urandom, $urandom, $urandom, $urandom};
    step();
    start_i = 1'b0;
    repeat (4) step();
    rst_n_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    chk("rst5_busy", {127'b0, busy_o}, 128'h0);
    chk("rst5_done", {127'b0, done_o}, 128'h0);
    chk("rst5_valid", {127'b0, keys_valid_o}, 128'h0);
    chk("rst5_key1", dut_k[1], 128'h0);
    chk("rst5_key4", dut_k[4], 128'h0);
    run(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, lat, bcnt, vcnt);
    chk("rst5_rerun_key10", dut_k[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(0, 3)) step();
      run({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), lat, bcnt, vcnt);
      chk("rand_latency", 128'(lat), 128'd10);
    end

    rk = m_sched[10];
    repeat (30) step();
    chk("hold_valid", {127'b0, keys_valid_o}, 128'h1);
    chk("hold_key10", dut_k[10], rk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
